// File: rtl/tetris_input_pkg.sv
// Shared definitions for the keyboard front end.
// Holds the game-key index, PS/2 scan-code constants, the event encoding,
// the prefix FSM state type and the key -> event mapping helper.
package tetris_input_pkg;

  typedef enum logic [2:0] {
    KeyNewGame = 3'd0,
    KeyRotate  = 3'd1,
    KeyLeft    = 3'd2,
    KeyRight   = 3'd3,
    KeyDown    = 3'd4
  } key_e;

  localparam int unsigned NumKeys = 5;

  localparam logic [7:0] SC_EXT      = 8'hE0;
  localparam logic [7:0] SC_BRK      = 8'hF0;
  localparam logic [7:0] SC_PAUSE    = 8'hE1;
  localparam logic [7:0] SC_NEW_GAME = 8'h31;
  localparam logic [7:0] SC_ROTATE   = 8'h75;
  localparam logic [7:0] SC_LEFT     = 8'h6B;
  localparam logic [7:0] SC_RIGHT    = 8'h74;
  localparam logic [7:0] SC_DOWN     = 8'h72;

  // Event codes seen by the downstream CDC stage; zero is never queued.
  localparam logic [2:0] EV_NONE     = 3'd0;
  localparam logic [2:0] EV_NEW_GAME = 3'd1;
  localparam logic [2:0] EV_ROTATE   = 3'd2;
  localparam logic [2:0] EV_LEFT     = 3'd3;
  localparam logic [2:0] EV_RIGHT    = 3'd4;
  localparam logic [2:0] EV_DOWN     = 3'd5;

  typedef enum logic [2:0] {
    StIdle,
    StExt,
    StBrk,
    StExtBrk,
    StPause
  } prefix_state_e;

  // Bytes swallowed after the E1 that opens the Pause/Break sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  function automatic logic [2:0] key_to_event(key_e k);
    logic [2:0] ev;
    unique case (k)
      KeyNewGame: ev = EV_NEW_GAME;
      KeyRotate:  ev = EV_ROTATE;
      KeyLeft:    ev = EV_LEFT;
      KeyRight:   ev = EV_RIGHT;
      KeyDown:    ev = EV_DOWN;
      default:    ev = EV_NONE;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/ps2_key_event_decoder_event_sfifo.sv
// Synchronous FIFO with count-based full/empty.
// Ports: i_clk/i_rst (async active-high) clock and reset, i_flush empties the
// queue, i_push/i_data write side (ignored when full), i_pop read side
// (ignored when empty), o_data registered head, o_empty/o_full status.
module event_sfifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr;
  logic [PtrW-1:0]  r_rd;
  logic [CntW-1:0]  r_cnt;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Full is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign w_push_ok = i_push && (r_cnt != FullCnt);
  assign w_pop_ok  = i_pop && (r_cnt != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      // Collapse onto the read pointer so the visible head stays put.
      r_wr  <= r_rd;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + PtrW'(1);
      end
      if (w_pop_ok) begin
        r_rd <= r_rd + PtrW'(1);
      end
      if (w_push_ok && !w_pop_ok) begin
        r_cnt <= r_cnt + CntW'(1);
      end else if (!w_push_ok && w_pop_ok) begin
        r_cnt <= r_cnt - CntW'(1);
      end
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == FullCnt);

endmodule

// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code decoder for the five game keys.
// Parses E0/F0/E1 prefixes, tracks held keys, suppresses keyboard typematic,
// generates its own auto-repeat and queues events for the consumer.
// Ports: ps2_clk/rst clock and async active-high reset; ps2_key_data_i and
// ps2_key_data_en_i incoming bytes; flush_i clears queue/held/repeat state;
// event_o/event_valid_o/event_ready_i output queue handshake; held_keys_o
// held state per key; overflow_cnt_o saturating count of dropped events.
module ps2_key_event_decoder
  import tetris_input_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned REPEAT_DELAY  = 750000,
  parameter int unsigned REPEAT_PERIOD = 150000,
  parameter logic [4:0]  REPEAT_MASK   = 5'b11100,
  parameter int unsigned OVF_W         = 8
) (
  input  logic             ps2_clk,
  input  logic             rst,
  input  logic [7:0]       ps2_key_data_i,
  input  logic             ps2_key_data_en_i,
  input  logic             flush_i,
  input  logic             event_ready_i,
  output logic [2:0]       event_o,
  output logic             event_valid_o,
  output logic [4:0]       held_keys_o,
  output logic [OVF_W-1:0] overflow_cnt_o
);

  localparam logic [OVF_W-1:0] OvfOne = OVF_W'(1);

  prefix_state_e    r_state;
  prefix_state_e    w_state_d;
  logic [2:0]       r_skip;
  logic [2:0]       w_skip_d;
  logic             w_make;
  logic             w_brk;
  logic             w_ext;
  logic             w_hit;
  key_e             w_key;

  logic [4:0]       r_held;
  logic             r_push;
  logic [2:0]       r_push_ev;
  logic             r_rep_active;
  logic             r_pending;
  key_e             r_rep_key;
  logic [31:0]      r_timer;
  logic [OVF_W-1:0] r_ovf;

  logic             w_push;
  logic [2:0]       w_push_data;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;

  // Prefix FSM state register.
  always_ff @(posedge ps2_clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_skip  <= '0;
    end else if (flush_i) begin
      r_state <= StIdle;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_d;
      r_skip  <= w_skip_d;
    end
  end

  // Next state and make/break classification of the current byte.
  always_comb begin
    w_state_d = r_state;
    w_skip_d  = r_skip;
    w_make    = 1'b0;
    w_brk     = 1'b0;
    w_ext     = 1'b0;
    if (ps2_key_data_en_i) begin
      unique case (r_state)
        StIdle: begin
          if (ps2_key_data_i == SC_EXT) begin
            w_state_d = StExt;
          end else if (ps2_key_data_i == SC_BRK) begin
            w_state_d = StBrk;
          end else if (ps2_key_data_i == SC_PAUSE) begin
            w_state_d = StPause;
            w_skip_d  = PAUSE_SKIP;
          end else begin
            w_make = 1'b1;
          end
        end
        StExt: begin
          if (ps2_key_data_i == SC_BRK) begin
            w_state_d = StExtBrk;
          end else begin
            w_make    = 1'b1;
            w_ext     = 1'b1;
            w_state_d = StIdle;
          end
        end
        StBrk: begin
          w_brk     = 1'b1;
          w_state_d = StIdle;
        end
        StExtBrk: begin
          w_brk     = 1'b1;
          w_ext     = 1'b1;
          w_state_d = StIdle;
        end
        StPause: begin
          w_skip_d = r_skip - 3'd1;
          if (r_skip <= 3'd1) begin
            w_state_d = StIdle;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Key map on (ext, code).
  always_comb begin
    w_hit = 1'b1;
    w_key = KeyNewGame;
    if (!w_ext && ps2_key_data_i == SC_NEW_GAME) begin
      w_key = KeyNewGame;
    end else if (w_ext && ps2_key_data_i == SC_ROTATE) begin
      w_key = KeyRotate;
    end else if (w_ext && ps2_key_data_i == SC_LEFT) begin
      w_key = KeyLeft;
    end else if (w_ext && ps2_key_data_i == SC_RIGHT) begin
      w_key = KeyRight;
    end else if (w_ext && ps2_key_data_i == SC_DOWN) begin
      w_key = KeyDown;
    end else begin
      w_hit = 1'b0;
    end
  end

  // Held state, registered decode push and auto-repeat timer.
  always_ff @(posedge ps2_clk or posedge rst) begin
    if (rst) begin
      r_held       <= '0;
      r_push       <= 1'b0;
      r_push_ev    <= EV_NONE;
      r_rep_active <= 1'b0;
      r_pending    <= 1'b0;
      r_rep_key    <= KeyNewGame;
      r_timer      <= '0;
    end else if (flush_i) begin
      r_held       <= '0;
      r_push       <= 1'b0;
      r_rep_active <= 1'b0;
      r_pending    <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_push <= 1'b0;
      // A pending repeat drains on any cycle the decoder is not pushing.
      if (r_pending && !r_push) begin
        r_pending <= 1'b0;
      end
      if (r_rep_active) begin
        if (r_timer == '0) begin
          r_pending <= 1'b1;
          // The zero cycle counts toward the period.
          r_timer   <= REPEAT_PERIOD - 32'd1;
        end else begin
          r_timer <= r_timer - 32'd1;
        end
      end
      if (w_make && w_hit && !r_held[w_key]) begin
        r_held[w_key] <= 1'b1;
        r_push        <= 1'b1;
        r_push_ev     <= key_to_event(w_key);
        if (REPEAT_MASK[w_key]) begin
          r_rep_key    <= w_key;
          r_timer      <= REPEAT_DELAY;
          r_rep_active <= 1'b1;
          r_pending    <= 1'b0;
        end
      end
      if (w_brk && w_hit) begin
        r_held[w_key] <= 1'b0;
        if (w_key == r_rep_key) begin
          r_rep_active <= 1'b0;
          r_pending    <= 1'b0;
        end
      end
    end
  end

  assign w_push      = r_push || r_pending;
  assign w_push_data = r_push ? r_push_ev : key_to_event(r_rep_key);
  assign w_pop       = event_valid_o && event_ready_i;

  always_ff @(posedge ps2_clk or posedge rst) begin
    if (rst) begin
      r_ovf <= '0;
    end else if (!flush_i && w_push && w_full && (r_ovf != {OVF_W{1'b1}})) begin
      r_ovf <= r_ovf + OvfOne;
    end
  end

  event_sfifo #(
    .WIDTH (3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (ps2_clk),
    .i_rst   (rst),
    .i_flush (flush_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (event_o),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign event_valid_o  = !w_empty;
  assign held_keys_o    = r_held;
  assign overflow_cnt_o = r_ovf;

endmodule
